// File: rtl/booth_mult_r4_pkg.sv
// rtl/booth_mult_r4_pkg.sv - shared types and helpers for the radix-4 Booth multiplier
package booth_mult_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  typedef enum logic [2:0] {R_ZERO, R_P1, R_P2, R_M1, R_M2} recode_e;

  // Operands are widened by two bits, and each iteration retires two of them
  function automatic int iter_count(input int width);
    return (width + 2) / 2;
  endfunction

endpackage

// File: rtl/booth_mult_r4_if.sv
// rtl/booth_mult_r4_if.sv - start/busy/done request and result bundle for booth_mult_r4
interface booth_mult_r4_if #(
  parameter int WIDTH = 8
) ();

  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, signed_mode, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, multiplicand, multiplier,
    output busy, done, product
  );

endinterface

// File: rtl/booth_mult_r4_recoder.sv
// rtl/booth_mult_r4_recoder.sv - radix-4 Booth digit recode of a 3-bit window into a signed addend
module booth_r4_recoder
  import booth_mult_pkg::*;
#(
  parameter int W2 = 10
) (
  input  logic [2:0]    window,
  input  logic [W2-1:0] mreg,
  output logic [W2:0]   addend
);

  recode_e    sel;
  logic [W2:0] m1;
  logic [W2:0] m2;

  assign m1 = {mreg[W2-1], mreg};
  assign m2 = {mreg, 1'b0};

  always_comb begin
    sel = R_ZERO;
    case (window)
      3'b001, 3'b010: sel = R_P1;
      3'b011:         sel = R_P2;
      3'b100:         sel = R_M2;
      3'b101, 3'b110: sel = R_M1;
      default:        sel = R_ZERO;
    endcase
  end

  // Negative digits reuse the adder: two's complement of the positive multiple
  always_comb begin
    addend = '0;
    case (sel)
      R_P1:    addend = m1;
      R_P2:    addend = m2;
      R_M1:    addend = ~m1 + (W2+1)'(1);
      R_M2:    addend = ~m2 + (W2+1)'(1);
      default: addend = '0;
    endcase
  end

endmodule

// File: rtl/booth_mult_r4.sv
// rtl/booth_mult_r4.sv - sequential radix-4 Booth multiplier; BOOTH_MULT_R4_EARLY_EXIT_EN enables early exit
module booth_mult_r4
  import booth_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  booth_mult_r4_if.slave bus
);

  localparam int W2 = WIDTH + 2;
  localparam int N  = iter_count(WIDTH);
  localparam int CW = $clog2(N + 1);
  localparam int TW = 2 * W2 + 2;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_DONE = DONE;

  generate
    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("booth_mult_r4: WIDTH must be even and >= 4");
    end
  endgenerate

  logic [1:0]         state;
  logic [W2:0]        acc;
  logic [W2-1:0]      qreg;
  logic               q_m1;
  logic [CW-1:0]      cnt;
  logic [W2-1:0]      mreg;
  logic [2*WIDTH-1:0] product_q;

  logic               accept;
  logic [W2-1:0]      ext_m;
  logic [W2-1:0]      ext_q;
  logic [W2:0]        addend;
  logic [W2:0]        sum;
  logic [TW-1:0]      step;
  logic               last;

  assign accept = bus.start && (state == S_IDLE || state == S_DONE);
  assign ext_m  = bus.signed_mode ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                                  : {2'b00, bus.multiplicand};
  assign ext_q  = bus.signed_mode ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier}
                                  : {2'b00, bus.multiplier};

  booth_r4_recoder #(.W2(W2)) u_recoder (
    .window (  {qreg[1:0], q_m1}),
    .mreg   (mreg),
    .addend (addend)
  );

  assign sum  = acc + addend;
  assign step = $signed({sum, qreg, q_m1}) >>> 2;
  assign last = (cnt == CW'(N - 1));

`ifdef BOOTH_MULT_R4_EARLY_EXIT_EN
  logic          q_sign;
  logic          tail_ok;
  logic [7:0]    shamt;
  logic [TW-1:0] skip_full;

  // Remaining windows are all 000/111 once the unretired bits match the sign
  always_comb begin
    tail_ok = (q_m1 == q_sign);
    for (int i = 0; i < W2; i++) begin
      if (i < W2 - 2 * int'(cnt) && qreg[i] != q_sign) tail_ok = 1'b0;
    end
  end

  assign shamt     = 8'(2 * (N - int'(cnt)));
  assign skip_full = $signed({acc, qreg, q_m1}) >>> shamt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      qreg      <= '0;
      q_m1      <= 1'b0;
      cnt       <= '0;
      mreg      <= '0;
      product_q <= '0;
`ifdef BOOTH_MULT_R4_EARLY_EXIT_EN
      q_sign    <= 1'b0;
`endif
    end else if (accept) begin
      state <= S_CALC;
      acc   <= '0;
      qreg  <= ext_q;
      q_m1  <= 1'b0;
      cnt   <= '0;
      mreg  <= ext_m;
`ifdef BOOTH_MULT_R4_EARLY_EXIT_EN
      q_sign <= ext_q[W2-1];
`endif
    end else begin
      case (state)
        S_CALC: begin
`ifdef BOOTH_MULT_R4_EARLY_EXIT_EN
          if (tail_ok) begin
            product_q <= skip_full[2*WIDTH:1];
            state     <= S_DONE;
          end else
`endif
          begin
            acc  <= step[TW-1 -: W2+1];
            qreg <= step[W2:1];
            q_m1 <= step[0];
            cnt  <= cnt + 1'b1;
            if (last) begin
              product_q <= step[2*WIDTH:1];
              state     <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = (state == S_CALC);
  assign bus.done    = (state == S_DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_booth_mult_r4.sv
// tb/tb_booth_mult_r4.sv - directed self-checking bench for booth_mult_r4
module tb_booth_mult_r4;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_mult_r4_if #(.WIDTH(WIDTH)) bus ();

  booth_mult_r4 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic sm, input logic [7:0] m, input logic [7:0] q);
    @(negedge clk);
    bus.signed_mode  = sm;
    bus.multiplicand = m;
    bus.multiplier   = q;
    bus.start        = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // lat counts negedges after the accepting edge; glitch_at>0 pulses a stray start mid-run
  task automatic wait_done(input int glitch_at, output int lat, output logic [15:0] p);
    lat = 0;
    p   = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (bus.done) begin
        p = bus.product;
        return;
      end
      if (glitch_at > 0 && lat == glitch_at) begin
        bus.start        = 1'b1;
        bus.signed_mode  = 1'b1;
        bus.multiplicand = 8'h11;
        bus.multiplier   = 8'h22;
      end
      if (glitch_at > 0 && lat == glitch_at + 1) bus.start = 1'b0;
    end
    check("done_timeout", 32'd0, 32'd1);
    lat = -1;
  endtask

  task automatic op(input string tag, input logic sm, input logic [7:0] m,
                    input logic [7:0] q, input logic [15:0] exp_p);
    int          lat;
    logic [15:0] p;
    issue(sm, m, q);
    wait_done(0, lat, p);
    check(tag, 32'(p), 32'(exp_p));
`ifndef BOOTH_MULT_R4_EARLY_EXIT_EN
    check({tag, "_lat"}, 32'(lat), 32'd6);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [15:0] p;
    logic        saw;
    logic [7:0]  rm, rq;
    logic [15:0] rexp;

    bus.start        = 1'b0;
    bus.signed_mode  = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_product", 32'(bus.product), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);

    op("s_m128_m128", 1'b1, 8'h80, 8'h80, 16'h4000);
    op("u_ff_ff",     1'b0, 8'hFF, 8'hFF, 16'hFE01);
    op("s_ff_ff",     1'b1, 8'hFF, 8'hFF, 16'h0001);
    op("s_127_m1",    1'b1, 8'h7F, 8'hFF, 16'hFF81);
    op("u_0_ab",      1'b0, 8'h00, 8'hAB, 16'h0000);
    op("s_m128_127",  1'b1, 8'h80, 8'h7F, 16'hC080);
    op("u_80_7f",     1'b0, 8'h80, 8'h7F, 16'h3F80);

    issue(1'b0, 8'h05, 8'h07);
    wait_done(2, lat, p);
    check("glitch_product", 32'(p), 32'h0023);
`ifndef BOOTH_MULT_R4_EARLY_EXIT_EN
    check("glitch_lat", 32'(lat), 32'd6);
`endif

    issue(1'b1, 8'h03, 8'h05);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_product", 32'(bus.product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      saw = saw | bus.done;
    end
    check("arst_no_done", 32'(saw), 32'd0);
    op("post_rst_s_3_m4", 1'b1, 8'h03, 8'hFC, 16'hFFF4);

    @(negedge clk);
    bus.signed_mode  = 1'b0;
    bus.multiplicand = 8'h10;
    bus.multiplier   = 8'h10;
    bus.start        = 1'b1;
    @(posedge clk);
    #1;
    bus.signed_mode  = 1'b1;
    bus.multiplicand = 8'hFE;
    bus.multiplier   = 8'h03;
    wait_done(0, lat, p);
    check("b2b_first", 32'(p), 32'h0100);
`ifndef BOOTH_MULT_R4_EARLY_EXIT_EN
    check("b2b_first_lat", 32'(lat), 32'd6);
`endif
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("b2b_no_idle", 32'(bus.busy), 32'd1);
    wait_done(0, lat, p);
    check("b2b_second", 32'(p), 32'hFFFA);
`ifndef BOOTH_MULT_R4_EARLY_EXIT_EN
    check("b2b_second_lat", 32'(lat), 32'd6);
`endif

`ifdef BOOTH_MULT_R4_EARLY_EXIT_EN
    issue(1'b0, 8'h55, 8'h00);
    wait_done(0, lat, p);
    check("ee_q0_product", 32'(p), 32'h0000);
    check("ee_q0_lat", 32'(lat), 32'd2);
`endif

    for (int i = 0; i < 200; i++) begin
      rm = 8'($urandom);
      rq = 8'($urandom);
      if (i[0]) rexp = 16'(int'($signed(rm)) * int'($signed(rq)));
      else      rexp = 16'(int'(rm) * int'(rq));
      op($sformatf("sweep%0d", i), i[0], rm, rq, rexp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
